// File: rtl/fpp_sequencer.sv
// fpp_sequencer: instruction sequencer in front of the 16-bit floating-point ALU.
// Holds an 8-entry half-precision register file and runs one instruction at a
// time: ISSUE pulses the ALU start, WAIT looks for a rising edge on the ALU
// completion level, and WB writes the result back or emits a STORE result.
// SUB is a NEG pass followed by an ADD pass. CLR is executed locally.
module fpp_sequencer #(
    parameter int NREG    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] imm,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        alu_st,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_data,
    output logic [15:0] alu_rega,
    output logic [15:0] alu_regb,
    input  logic [15:0] alu_regout,
    input  logic        alu_en,
    input  logic        alu_flag_io
);

    localparam int CW = $clog2(TIMEOUT);

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_MOV   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_NEG   = 4'b0011;
    localparam logic [3:0] OP_STORE = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_MAX   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_CLR   = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t          r_state;
    logic [15:0]     r_regs [0:NREG-1];
    logic [3:0]      r_op;
    logic [2:0]      r_rd;
    logic [2:0]      r_ra;
    logic [1:0]      r_phase;     // 0 single pass, 1 SUB negate pass, 2 SUB add pass
    logic            r_en_q;
    logic [CW-1:0]   r_cnt;
    logic            r_flag;

    logic [3:0]      w_opcode;
    logic [2:0]      w_rd;
    logic [2:0]      w_ra;
    logic [2:0]      w_rb;
    logic            w_is_alu;
    logic            w_is_clr;
    logic            w_complete;
    logic            w_unused_bits;

    assign w_opcode      = instr[15:12];
    assign w_rd          = instr[11:9];
    assign w_ra          = instr[8:6];
    assign w_rb          = instr[5:3];
    assign w_is_clr      = (w_opcode == OP_CLR);
    assign w_complete    = alu_en & ~r_en_q;
    assign w_unused_bits = ^instr[2:0];

    // Decode which opcodes are dispatched to the ALU.
    always_comb begin
        w_is_alu = 1'b0;
        case (w_opcode)
            OP_LOAD, OP_MOV, OP_ADD, OP_NEG,
            OP_STORE, OP_MUL, OP_MAX, OP_SUB: w_is_alu = 1'b1;
            default:                          w_is_alu = 1'b0;
        endcase
    end

    // Sequencer FSM, register file and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 16'h0000;
            end
            r_op        <= 4'b0000;
            r_rd        <= 3'd0;
            r_ra        <= 3'd0;
            r_phase     <= 2'd0;
            r_en_q      <= 1'b0;
            r_cnt       <= '0;
            r_flag      <= 1'b0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            err         <= 1'b0;
            err_code    <= 2'b00;
            alu_st      <= 1'b0;
            alu_func    <= 4'b0000;
            alu_data    <= 16'h0000;
            alu_rega    <= 16'h0000;
            alu_regb    <= 16'h0000;
        end else begin
            // Pulses default low; the completion detector samples every cycle.
            r_en_q    <= alu_en;
            out_valid <= 1'b0;
            err       <= 1'b0;
            alu_st    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        if (w_is_alu) begin
                            r_state     <= S_ISSUE;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                            alu_st      <= 1'b1;
                            r_op        <= w_opcode;
                            r_rd        <= w_rd;
                            r_ra        <= w_ra;
                            alu_data    <= imm;
                            alu_regb    <= r_regs[w_rb];
                            if (w_opcode == OP_SUB) begin
                                // First pass negates the subtrahend.
                                r_phase  <= 2'd1;
                                alu_func <= OP_NEG;
                                alu_rega <= r_regs[w_rb];
                            end else begin
                                r_phase  <= 2'd0;
                                alu_func <= w_opcode;
                                alu_rega <= r_regs[w_ra];
                            end
                        end else if (w_is_clr) begin
                            r_regs[w_rd] <= 16'h0000;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_complete) begin
                        r_flag  <= alu_flag_io;
                        r_state <= S_WB;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        err         <= 1'b1;
                        err_code    <= 2'b10;
                        r_state     <= S_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WB: begin
                    if (r_phase == 2'd1) begin
                        // alu_regb holds the negated intermediate for the add pass.
                        r_phase  <= 2'd2;
                        r_state  <= S_ISSUE;
                        alu_st   <= 1'b1;
                        alu_func <= OP_ADD;
                        alu_rega <= r_regs[r_ra];
                        alu_regb <= alu_regout;
                    end else begin
                        if (r_op == OP_STORE) begin
                            out_data  <= alu_regout;
                            out_valid <= 1'b1;
                            if (!r_flag) begin
                                err      <= 1'b1;
                                err_code <= 2'b11;
                            end
                        end else begin
                            r_regs[r_rd] <= alu_regout;
                        end
                        r_state     <= S_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpp_sequencer.sv
// Directed testbench for fpp_sequencer with a behavioural half-precision ALU.
module tb_fpp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic [15:0] imm = 16'h0000;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic        alu_st;
    logic [3:0]  alu_func;
    logic [15:0] alu_data;
    logic [15:0] alu_rega;
    logic [15:0] alu_regb;
    logic [15:0] alu_regout;
    logic        alu_en;
    logic        alu_flag_io;

    int n_checks = 0;
    int n_errors = 0;

    // ALU model controls
    logic        stall_alu = 1'b0;
    logic        flag_ok = 1'b1;
    logic [15:0] m_out;
    logic        m_en;
    int          m_cnt;

    // Monitor state
    logic [31:0] st_total = 32'd0;
    logic [31:0] ov_total = 32'd0;
    logic [31:0] err_total = 32'd0;
    logic [3:0]  st_log [0:15];
    logic [15:0] last_out = 16'h0000;
    logic [1:0]  last_code = 2'b00;

    assign alu_regout  = m_out;
    assign alu_en      = m_en;
    assign alu_flag_io = flag_ok;

    fpp_sequencer #(.NREG(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .imm(imm), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .err(err), .err_code(err_code), .alu_st(alu_st),
        .alu_func(alu_func), .alu_data(alu_data), .alu_rega(alu_rega),
        .alu_regb(alu_regb), .alu_regout(alu_regout), .alu_en(alu_en),
        .alu_flag_io(alu_flag_io)
    );

    always #5 clk = ~clk;

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real        v;
        int         e;
        int         m;
        logic       s;
        logic [4:0] eb;
        logic [9:0] mb;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        m = int'((v - 1.0) * 1024.0);
        eb = e[4:0];
        mb = m[9:0];
        return {s, eb, mb};
    endfunction

    function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] d);
        case (f)
            4'b0000: return d;
            4'b0001: return a;
            4'b0010: return r2h(h2r(a) + h2r(b));
            4'b0011: return a ^ 16'h8000;
            4'b0100: return a;
            4'b0110: return r2h(h2r(a) * h2r(b));
            4'b0111: return (h2r(a) >= h2r(b)) ? a : b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int alu_lat(input logic [3:0] f);
        case (f)
            4'b0010, 4'b0111: return 3;
            4'b0110:          return 4;
            default:          return 2;
        endcase
    endfunction

    // Behavioural ALU: reset from ~rst, completion level rises some edges after start.
    always @(posedge clk) begin
        if (!rst) begin
            m_en  <= 1'b0;
            m_out <= 16'h0000;
            m_cnt <= 0;
        end else if (alu_st) begin
            m_en  <= 1'b0;
            m_cnt <= alu_lat(alu_func);
            m_out <= alu_calc(alu_func, alu_rega, alu_regb, alu_data);
        end else if (m_cnt != 0 && !stall_alu) begin
            if (m_cnt == 1) m_en <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    // Record start pulses, STORE results and error pulses away from the active edge.
    always @(negedge clk) begin
        if (alu_st) begin
            st_log[st_total[3:0]] <= alu_func;
            st_total <= st_total + 32'd1;
        end
        if (out_valid) begin
            ov_total <= ov_total + 32'd1;
            last_out <= out_data;
        end
        if (err) begin
            err_total <= err_total + 32'd1;
            last_code <= err_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    // Offer one instruction and return #1 after its acceptance edge.
    task automatic send(input logic [15:0] w, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = w;
        imm = d;
        while (!instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic run(input logic [15:0] w, input logic [15:0] d);
        send(w, d);
        wait_idle();
    endtask

    task automatic store_check(input string tag, input logic [2:0] rs, input logic [15:0] exp);
        logic [31:0] ov0;
        ov0 = ov_total;
        run(mk(4'b0100, 3'd0, rs, 3'd0), 16'h0000);
        chk({tag, "_ov"}, ov_total - ov0, 32'd1);
        chk(tag, {16'd0, last_out}, {16'd0, exp});
    endtask

    initial begin
        logic [31:0] st0;
        logic [31:0] e0;
        int          edges;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_st", {31'd0, alu_st}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        chk("rst_outdata", {16'd0, out_data}, 32'd0);
        chk("rst_func", {28'd0, alu_func}, 32'd0);
        chk("rst_ops", {alu_rega, alu_regb}, 32'd0);
        chk("rst_data", {16'd0, alu_data}, 32'd0);
        rst = 1'b1;

        // LOAD R1 with latency checks (acceptance edge is edge 0)
        send(mk(4'b0000, 3'd1, 3'd0, 3'd0), 16'h3C00);
        chk("lat_st_c1", {31'd0, alu_st}, 32'd1);
        chk("lat_busy_c1", {31'd0, busy}, 32'd1);
        chk("lat_ready_c1", {31'd0, instr_ready}, 32'd0);
        chk("lat_func", {28'd0, alu_func}, 32'd0);
        chk("lat_data", {16'd0, alu_data}, 32'h3C00);
        @(posedge clk); #1;
        chk("lat_st_c2", {31'd0, alu_st}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("lat_ready_e4", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        chk("lat_ready_e5", {31'd0, instr_ready}, 32'd1);
        chk("lat_busy_e5", {31'd0, busy}, 32'd0);

        // LOAD R2, ADD R3 = R1 + R2, STORE R3
        run(mk(4'b0000, 3'd2, 3'd0, 3'd0), 16'h4000);
        run(mk(4'b0010, 3'd3, 3'd1, 3'd2), 16'h0000);
        e0 = err_total;
        store_check("add", 3'd3, 16'h4200);
        chk("add_noerr", err_total - e0, 32'd0);

        // SUB R4 = R2 - R1: NEG pass then ADD pass
        st0 = st_total;
        run(mk(4'b1000, 3'd4, 3'd2, 3'd1), 16'h0000);
        chk("sub_nst", st_total - st0, 32'd2);
        chk("sub_f1", {28'd0, st_log[st0[3:0]]}, 32'd3);
        chk("sub_f2", {28'd0, st_log[st0[3:0] + 4'd1]}, 32'd2);
        store_check("sub", 3'd4, 16'h3C00);

        // MUL, NEG, MAX
        run(mk(4'b0110, 3'd5, 3'd2, 3'd2), 16'h0000);
        store_check("mul", 3'd5, 16'h4400);
        run(mk(4'b0011, 3'd7, 3'd1, 3'd0), 16'h0000);
        store_check("neg", 3'd7, 16'hBC00);
        run(mk(4'b0111, 3'd6, 3'd7, 3'd1), 16'h0000);
        store_check("max", 3'd6, 16'h3C00);

        // Illegal opcodes: DIV and 1111, both targeting R1
        st0 = st_total;
        e0 = err_total;
        send(mk(4'b0101, 3'd1, 3'd2, 3'd2), 16'h0000);
        chk("ill_ready", {31'd0, instr_ready}, 32'd1);
        send(mk(4'b1111, 3'd1, 3'd2, 3'd2), 16'h0000);
        repeat (2) @(negedge clk);
        chk("ill_nerr", err_total - e0, 32'd2);
        chk("ill_code", {30'd0, last_code}, 32'd1);
        chk("ill_nst", st_total - st0, 32'd0);
        store_check("ill_r1", 3'd1, 16'h3C00);

        // CLR R3 executes locally
        st0 = st_total;
        send(mk(4'b1001, 3'd3, 3'd0, 3'd0), 16'h0000);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk("clr_nst", st_total - st0, 32'd0);
        store_check("clr", 3'd3, 16'h0000);

        // ALU timeout on ADD R1 = R1 + R2
        stall_alu = 1'b1;
        send(mk(4'b0010, 3'd1, 3'd1, 3'd2), 16'h0000);
        edges = 0;
        while (!err && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("to_edges", edges, 32'd65);
        chk("to_code", {30'd0, err_code}, 32'd2);
        chk("to_ready", {31'd0, instr_ready}, 32'd1);
        stall_alu = 1'b0;
        wait_idle();
        store_check("to_r1", 3'd1, 16'h3C00);

        // STORE with the ALU I/O flag low
        flag_ok = 1'b0;
        e0 = err_total;
        store_check("flag", 3'd2, 16'h4000);
        chk("flag_nerr", err_total - e0, 32'd1);
        chk("flag_code", {30'd0, last_code}, 32'd3);
        flag_ok = 1'b1;

        // Reset in the middle of WAIT
        stall_alu = 1'b1;
        send(mk(4'b0010, 3'd5, 3'd1, 3'd2), 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_ready", {31'd0, instr_ready}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_st", {31'd0, alu_st}, 32'd0);
        chk("mr_code", {30'd0, err_code}, 32'd0);
        chk("mr_outdata", {16'd0, out_data}, 32'd0);
        rst = 1'b1;
        stall_alu = 1'b0;
        store_check("mr_r1", 3'd1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
